// File: rtl/exe_pkg.sv
// Shared types and constants for the execute stage.
// Contents:
//   WORD        - datapath width
//   alu_func_e  - 4-bit ALU operation code
//   opsel1_e    - operand A select
//   opsel2_e    - operand B select
//   wbsel_e     - writeback source select; carried through this stage unchanged
package exe_pkg;

  localparam int unsigned WORD = 32;

  typedef enum logic [3:0] {
    AluPassA = 4'b0000,
    AluAdd   = 4'b0001,
    AluSub   = 4'b0010,
    AluAnd   = 4'b0011,
    AluOr    = 4'b0100,
    AluXor   = 4'b0101,
    AluSll   = 4'b0110,
    AluSrl   = 4'b0111,
    AluSra   = 4'b1000,
    AluSlt   = 4'b1001,
    AluSltu  = 4'b1010,
    AluPassB = 4'b1011
  } alu_func_e;

  // 2'b10 and 2'b11 both select zero; 2'b11 reaches that value through the mux default
  typedef enum logic [1:0] {
    Op1Rs1  = 2'b00,
    Op1Pc   = 2'b01,
    Op1Zero = 2'b10
  } opsel1_e;

  typedef enum logic [1:0] {
    Op2Rs2   = 2'b00,
    Op2Imm   = 2'b01,
    Op2Four  = 2'b10,
    Op2Zero  = 2'b11
  } opsel2_e;

  typedef enum logic [1:0] {
    WbAlu = 2'b00,
    WbMem = 2'b01,
    WbPc4 = 2'b10,
    WbRsv = 2'b11
  } wbsel_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   a, b      - operands (WORD bits)
//   alu_func  - operation code, see exe_pkg::alu_func_e; undefined codes yield 0
//   result    - operation result (WORD bits)
module alu
  import exe_pkg::*;
#(
  parameter int unsigned WORD = exe_pkg::WORD
) (
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  input  logic [3:0]      alu_func,
  output logic [WORD-1:0] result
);

  localparam int unsigned ShW = $clog2(WORD);

  logic [ShW-1:0] shamt;
  logic           lt_signed;
  logic           lt_unsigned;

  // Only the low bits of b form the shift amount; the rest are ignored
  assign shamt       = b[ShW-1:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    result = '0;
    case (alu_func_e'(alu_func))
      AluPassA: result = a;
      AluAdd:   result = a + b;
      AluSub:   result = a - b;
      AluAnd:   result = a & b;
      AluOr:    result = a | b;
      AluXor:   result = a ^ b;
      AluSll:   result = a << shamt;
      AluSrl:   result = a >> shamt;
      AluSra:   result = WORD'($signed(a) >>> shamt);
      AluSlt:   result = {{(WORD-1){1'b0}}, lt_signed};
      AluSltu:  result = {{(WORD-1){1'b0}}, lt_unsigned};
      AluPassB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage of the in-order RV32 pipeline: operand selection, ALU, and the EX/MEM register.
// Ports:
//   clk, reset (async, active-low)
//   rs1_data_i, rs2_data_i, imm, pc_i   - operand sources
//   opsel1, opsel2, alu_func            - operand selects and ALU op
//   rd_addr_i, rf_w_en_i, mem_w_en_i, wbsel_i - control passed down the pipe
//   pc_o, alu_out, rd_addr_o, rf_w_en_o, mem_w_en_o, wbsel_o, rs2_data_o - EX/MEM register
// Optional: define EXECUTE_FLUSH_EN to add flush_i, which turns the captured instruction into
// a bubble (control fields zeroed; pc, result and store data still captured).
module execute_stage
  import exe_pkg::*;
#(
  parameter int unsigned WORD     = exe_pkg::WORD,
  parameter int unsigned ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
`ifdef EXECUTE_FLUSH_EN
  input  logic                flush_i,
`endif
  input  logic [WORD-1:0]     rs1_data_i,
  input  logic [WORD-1:0]     rs2_data_i,
  input  logic [WORD-1:0]     imm,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic [1:0]          opsel1,
  input  logic [1:0]          opsel2,
  input  logic [3:0]          alu_func,
  input  logic [4:0]          rd_addr_i,
  input  logic                rf_w_en_i,
  input  logic                mem_w_en_i,
  input  logic [1:0]          wbsel_i,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [WORD-1:0]     alu_out,
  output logic [4:0]          rd_addr_o,
  output logic                rf_w_en_o,
  output logic                mem_w_en_o,
  output logic [1:0]          wbsel_o,
  output logic [WORD-1:0]     rs2_data_o
);

  logic [WORD-1:0] pc_ext;
  logic [WORD-1:0] op_a;
  logic [WORD-1:0] op_b;
  logic [WORD-1:0] alu_result;

  // PC is zero-extended or truncated to the datapath width
  if (ADDR_LEN >= WORD) begin : g_pc_trunc
    assign pc_ext = pc_i[WORD-1:0];
  end else begin : g_pc_zext
    assign pc_ext = {{(WORD-ADDR_LEN){1'b0}}, pc_i};
  end

  // Full muxes: an unselected source never reaches the ALU
  always_comb begin
    op_a = '0;
    case (opsel1_e'(opsel1))
      Op1Rs1:  op_a = rs1_data_i;
      Op1Pc:   op_a = pc_ext;
      default: op_a = '0;
    endcase
  end

  always_comb begin
    op_b = '0;
    case (opsel2_e'(opsel2))
      Op2Rs2:  op_b = rs2_data_i;
      Op2Imm:  op_b = imm;
      Op2Four: op_b = WORD'(4);
      default: op_b = '0;
    endcase
  end

  alu #(
    .WORD(WORD)
  ) alu0 (
    .a        (op_a),
    .b        (op_b),
    .alu_func (alu_func),
    .result   (alu_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_o       <= '0;
      alu_out    <= '0;
      rd_addr_o  <= '0;
      rf_w_en_o  <= 1'b0;
      mem_w_en_o <= 1'b0;
      wbsel_o    <= '0;
      rs2_data_o <= '0;
    end else begin
      pc_o       <= pc_i;
      alu_out    <= alu_result;
      rs2_data_o <= rs2_data_i;
`ifdef EXECUTE_FLUSH_EN
      if (flush_i) begin
        rd_addr_o  <= '0;
        rf_w_en_o  <= 1'b0;
        mem_w_en_o <= 1'b0;
        wbsel_o    <= '0;
      end else begin
        rd_addr_o  <= rd_addr_i;
        rf_w_en_o  <= rf_w_en_i;
        mem_w_en_o <= mem_w_en_i;
        wbsel_o    <= wbsel_i;
      end
`else
      rd_addr_o  <= rd_addr_i;
      rf_w_en_o  <= rf_w_en_i;
      mem_w_en_o <= mem_w_en_i;
      wbsel_o    <= wbsel_i;
`endif
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

  logic        clk;
  logic        reset;
`ifdef EXECUTE_FLUSH_EN
  logic        flush_i;
`endif
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm;
  logic [31:0] pc_i;
  logic [1:0]  opsel1;
  logic [1:0]  opsel2;
  logic [3:0]  alu_func;
  logic [4:0]  rd_addr_i;
  logic        rf_w_en_i;
  logic        mem_w_en_i;
  logic [1:0]  wbsel_i;
  logic [31:0] pc_o;
  logic [31:0] alu_out;
  logic [4:0]  rd_addr_o;
  logic        rf_w_en_o;
  logic        mem_w_en_o;
  logic [1:0]  wbsel_o;
  logic [31:0] rs2_data_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  execute_stage dut (
    .clk        (clk),
    .reset      (reset),
`ifdef EXECUTE_FLUSH_EN
    .flush_i    (flush_i),
`endif
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .imm        (imm),
    .pc_i       (pc_i),
    .opsel1     (opsel1),
    .opsel2     (opsel2),
    .alu_func   (alu_func),
    .rd_addr_i  (rd_addr_i),
    .rf_w_en_i  (rf_w_en_i),
    .mem_w_en_i (mem_w_en_i),
    .wbsel_i    (wbsel_i),
    .pc_o       (pc_o),
    .alu_out    (alu_out),
    .rd_addr_o  (rd_addr_o),
    .rf_w_en_o  (rf_w_en_o),
    .mem_w_en_o (mem_w_en_o),
    .wbsel_o    (wbsel_o),
    .rs2_data_o (rs2_data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pc_o"}, pc_o, 32'h0);
    check({tag, ".alu_out"}, alu_out, 32'h0);
    check({tag, ".rd_addr_o"}, {27'h0, rd_addr_o}, 32'h0);
    check({tag, ".rf_w_en_o"}, {31'h0, rf_w_en_o}, 32'h0);
    check({tag, ".mem_w_en_o"}, {31'h0, mem_w_en_o}, 32'h0);
    check({tag, ".wbsel_o"}, {30'h0, wbsel_o}, 32'h0);
    check({tag, ".rs2_data_o"}, rs2_data_o, 32'h0);
  endtask

  // Apply an ALU op at the falling edge, then sample 1 time unit after the capturing edge
  task automatic run_op(input logic [3:0] f, input logic [1:0] o1, input logic [1:0] o2,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] pc);
    @(negedge clk);
    alu_func   = f;
    opsel1     = o1;
    opsel2     = o2;
    rs1_data_i = a;
    rs2_data_i = b;
    imm        = im;
    pc_i       = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
`ifdef EXECUTE_FLUSH_EN
    flush_i    = 1'b0;
`endif
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    imm        = $urandom;
    pc_i       = $urandom;
    opsel1     = 2'($urandom);
    opsel2     = 2'($urandom);
    alu_func   = 4'($urandom);
    rd_addr_i  = 5'($urandom);
    rf_w_en_i  = 1'b1;
    mem_w_en_i = 1'b1;
    wbsel_i    = 2'b01;

    // Reset held across clock edges
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // Release and run the ADD sequence; each result lands one edge later
    @(negedge clk);
    reset      = 1'b1;
    rf_w_en_i  = 1'b0;
    mem_w_en_i = 1'b0;
    wbsel_i    = 2'b00;
    rd_addr_i  = 5'd0;
    run_op(4'b0001, 2'b00, 2'b00, 32'd4, 32'd2, 32'd0, 32'd1);
    check("add_4_2", alu_out, 32'd6);
    check("add_4_2.pc", pc_o, 32'd1);
    run_op(4'b0001, 2'b00, 2'b00, 32'd4, 32'd6, 32'd0, 32'd2);
    check("add_4_6", alu_out, 32'd10);
    check("add_4_6.pc", pc_o, 32'd2);
    run_op(4'b0001, 2'b00, 2'b00, 32'd14, 32'd22, 32'd0, 32'd4);
    check("add_14_22", alu_out, 32'd36);
    check("add_14_22.pc", pc_o, 32'd4);
    run_op(4'b0001, 2'b00, 2'b00, 32'd10, 32'd54, 32'd0, 32'd8);
    check("add_10_54", alu_out, 32'd64);
    check("add_10_54.pc", pc_o, 32'd8);

    // Operand selection
    run_op(4'b0001, 2'b01, 2'b10, 32'h1234, 32'h5678, 32'h9, 32'h100);
    check("jal_link", alu_out, 32'h104);
    run_op(4'b0001, 2'b00, 2'b01, 32'd5, 32'h7777, 32'hFFFF_FFFF, 32'h0);
    check("addi_neg1", alu_out, 32'd4);
    run_op(4'b0001, 2'b10, 2'b01, 32'hAAAA, 32'h0, 32'h55, 32'h200);
    check("opa_zero", alu_out, 32'h55);
    run_op(4'b0001, 2'b11, 2'b11, 32'hAAAA, 32'hBBBB, 32'h55, 32'h200);
    check("opa_opb_zero", alu_out, 32'h0);

    // Arithmetic, logic, compare and shift
    run_op(4'b0010, 2'b00, 2'b00, 32'd2, 32'd3, 32'h0, 32'h0);
    check("sub_wrap", alu_out, 32'hFFFF_FFFF);
    run_op(4'b0001, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
    check("add_wrap", alu_out, 32'd1);
    run_op(4'b1001, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    check("slt", alu_out, 32'd1);
    run_op(4'b1010, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    check("sltu", alu_out, 32'd0);
    run_op(4'b1010, 2'b00, 2'b00, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0);
    check("sltu_true", alu_out, 32'd1);
    run_op(4'b1000, 2'b00, 2'b00, 32'h8000_0000, 32'd4, 32'h0, 32'h0);
    check("sra", alu_out, 32'hF800_0000);
    run_op(4'b0111, 2'b00, 2'b00, 32'h8000_0000, 32'd4, 32'h0, 32'h0);
    check("srl", alu_out, 32'h0800_0000);
    run_op(4'b0110, 2'b00, 2'b00, 32'h0000_0001, 32'd33, 32'h0, 32'h0);
    check("sll_by_33", alu_out, 32'h0000_0002);
    run_op(4'b0111, 2'b00, 2'b00, 32'h8000_0000, 32'd33, 32'h0, 32'h0);
    check("srl_by_33", alu_out, 32'h4000_0000);
    run_op(4'b0011, 2'b00, 2'b00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 32'h0);
    check("and", alu_out, 32'h00F0_1200);
    run_op(4'b0100, 2'b00, 2'b00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 32'h0);
    check("or", alu_out, 32'hFFF0_FF34);
    run_op(4'b0101, 2'b00, 2'b00, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 32'h0);
    check("xor", alu_out, 32'hFF00_ED34);
    run_op(4'b0000, 2'b00, 2'b00, 32'hCAFE_0001, 32'h1111_2222, 32'h0, 32'h0);
    check("pass_a", alu_out, 32'hCAFE_0001);
    run_op(4'b1011, 2'b00, 2'b01, 32'hCAFE_0001, 32'h1111_2222, 32'h3333_4444, 32'h0);
    check("pass_b", alu_out, 32'h3333_4444);
    run_op(4'b1100, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    check("func_1100", alu_out, 32'h0);
    run_op(4'b1111, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    check("func_1111", alu_out, 32'h0);

    // Control and store-data pass-through
    @(negedge clk);
    rd_addr_i  = 5'd17;
    rf_w_en_i  = 1'b1;
    mem_w_en_i = 1'b1;
    wbsel_i    = 2'd2;
    run_op(4'b0001, 2'b00, 2'b00, 32'd1, 32'hDEAD_BEEF, 32'h0, 32'h44);
    check("pt.rd_addr_o", {27'h0, rd_addr_o}, 32'd17);
    check("pt.rf_w_en_o", {31'h0, rf_w_en_o}, 32'd1);
    check("pt.mem_w_en_o", {31'h0, mem_w_en_o}, 32'd1);
    check("pt.wbsel_o", {30'h0, wbsel_o}, 32'd2);
    check("pt.rs2_data_o", rs2_data_o, 32'hDEAD_BEEF);
    check("pt.alu_out", alu_out, 32'hDEAD_BEF0);
    check("pt.pc_o", pc_o, 32'h44);

`ifdef EXECUTE_FLUSH_EN
    @(negedge clk);
    flush_i = 1'b1;
    run_op(4'b0001, 2'b00, 2'b00, 32'd7, 32'd8, 32'h0, 32'h48);
    check("flush.rf_w_en_o", {31'h0, rf_w_en_o}, 32'd0);
    check("flush.mem_w_en_o", {31'h0, mem_w_en_o}, 32'd0);
    check("flush.rd_addr_o", {27'h0, rd_addr_o}, 32'd0);
    check("flush.wbsel_o", {30'h0, wbsel_o}, 32'd0);
    check("flush.alu_out", alu_out, 32'd15);
    check("flush.pc_o", pc_o, 32'h48);
    @(negedge clk);
    flush_i = 1'b0;
    run_op(4'b0001, 2'b00, 2'b00, 32'd1, 32'hDEAD_BEEF, 32'h0, 32'h44);
`endif

    // Asynchronous reset between edges: outputs clear with no clock edge
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check("reset_hold.alu_out", alu_out, 32'h0);
    check("reset_hold.rf_w_en_o", {31'h0, rf_w_en_o}, 32'd0);

    // Capture resumes on the first edge after release
    @(negedge clk);
    reset = 1'b1;
    run_op(4'b0001, 2'b00, 2'b00, 32'd100, 32'd23, 32'h0, 32'h80);
    check("post_reset.alu_out", alu_out, 32'd123);
    check("post_reset.pc_o", pc_o, 32'h80);
    check("post_reset.rd_addr_o", {27'h0, rd_addr_o}, 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
